adc_path_pack: RTL and testbench

- Packs a single-lane, rd_clk-domain sample stream into parallel multi-path words, lowest path first: sample k of a word lands in bits [(k+1)*W-1 : k*W].
- This is the inverse of the path-merge done after the ADC CDC FIFOs.
- Feeds DSP test paths and DAC/loopback interfaces that expect the PARALLEL_PATH_NUM-wide ADC bus format.
- Valid/ready handshake on both sides; double-buffered so it sustains 1 sample/cycle in and 1 word per PARALLEL_PATH_NUM cycles out.

---
 rtl/adc_path_pack_pkg.sv | 26 ++
 rtl/adc_path_pack_sat_cnt.sv | 29 ++
 rtl/adc_path_pack.sv | 97 +++++++++
 tb/tb_adc_path_pack.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/adc_path_pack_pkg.sv
// Shared definitions for the ADC path packer.
//   PATH_NUM_DEF       : samples per packed word (4 for RSR builds, 2 for PSR)
//   ADC_DATA_WIDTH_DEF : default bits per sample
//   DROP_CNT_WIDTH_DEF : default width of the partial-word drop counter
//   clog2b()           : ceil(log2(n)) with a floor of 1 bit, for counters
package adc_path_pack_pkg;

`ifdef RSR
  localparam int PATH_NUM_DEF = 4;
`else
  localparam int PATH_NUM_DEF = 2;
`endif

  localparam int ADC_DATA_WIDTH_DEF = 8;
  localparam int DROP_CNT_WIDTH_DEF = 16;

  // A counter over n states never gets fewer than one bit.
  function automatic int clog2b(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/adc_path_pack_sat_cnt.sv
// Saturating up-counter.
//   clk   : clock
//   rst   : synchronous active-high reset, clears the count
//   inc_i : count one event this cycle
//   cnt_o : current count, sticks at all-ones
module adc_path_pack_sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/adc_path_pack.sv
// Packs a single-lane sample stream into N-path words, path 0 in the LSBs.
// Lanes 0..N-2 collect in an assembly register; the lane N-1 sample is
// merged straight into the output register, so the block sustains one sample
// per cycle in and one word per N cycles out.
//   clk, rst  : clock, synchronous active-high reset
//   s_data    : input sample          s_valid : sample valid
//   s_sync    : sample is path 0      s_ready : sample accepted this cycle
//   m_data    : packed word           m_valid : word valid
//   m_ready   : downstream takes word
//   drop_cnt  : saturating count of partial words discarded by s_sync
module adc_path_pack
  import adc_path_pack_pkg::*;
#(
  parameter int ADC_DATA_WIDTH    = ADC_DATA_WIDTH_DEF,
  parameter int PARALLEL_PATH_NUM = PATH_NUM_DEF,
  parameter int DROP_CNT_WIDTH    = DROP_CNT_WIDTH_DEF
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [ADC_DATA_WIDTH-1:0]                   s_data,
  input  logic                                        s_valid,
  input  logic                                        s_sync,
  output logic                                        s_ready,
  output logic [ADC_DATA_WIDTH*PARALLEL_PATH_NUM-1:0] m_data,
  output logic                                        m_valid,
  input  logic                                        m_ready,
  output logic [DROP_CNT_WIDTH-1:0]                   drop_cnt
);

  localparam int W  = ADC_DATA_WIDTH;
  localparam int N  = PARALLEL_PATH_NUM;
  localparam int LW = clog2b(N);

  logic [LW-1:0]             lane_q, lane_d;
  logic [N-2:0][W-1:0]       asm_q, asm_d;
  logic [N*W-1:0]            mdata_q, mdata_d;
  logic                      mvalid_q, mvalid_d;
  logic                      last_lane, acc, xfer, drop_inc;

  assign last_lane = (lane_q == LW'(N-1));
  // Only the closing lane needs room in the output register; it can go in
  // on the same edge the pending word leaves.
  assign s_ready   = !rst && (!last_lane || !mvalid_q || m_ready);
  assign acc       = s_valid && s_ready;
  assign xfer      = mvalid_q && m_ready;
  assign drop_inc  = acc && s_sync && (lane_q != '0);

  always_comb begin
    lane_d   = lane_q;
    asm_d    = asm_q;
    mdata_d  = mdata_q;
    mvalid_d = mvalid_q;
    if (xfer) mvalid_d = 1'b0;
    if (acc) begin
      if (s_sync) begin
        // Realign: whatever was assembled is thrown away, this sample is path 0.
        asm_d    = '0;
        asm_d[0] = s_data;
        lane_d   = LW'(1);
      end else if (last_lane) begin
        mdata_d  = {s_data, asm_q};
        mvalid_d = 1'b1;  // overrides a same-cycle transfer clear
        asm_d    = '0;
        lane_d   = '0;
      end else begin
        for (int k = 0; k < N-1; k++)
          if (lane_q == LW'(k)) asm_d[k] = s_data;
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q   <= '0;
      asm_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      mdata_q  <= mdata_d;
      mvalid_q <= mvalid_d;
    end
  end

  adc_path_pack_sat_cnt #(.WIDTH(DROP_CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

  assign m_data  = mdata_q;
  assign m_valid = mvalid_q;

endmodule

// File: tb/tb_adc_path_pack.sv
module tb_adc_path_pack;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // a: N=2, 16-bit drop counter
  logic [7:0]  a_sd;  logic a_sv, a_ss, a_sr, a_mv, a_mr;
  logic [15:0] a_md;  logic [15:0] a_drop;
  // b: N=4
  logic [7:0]  b_sd;  logic b_sv, b_ss, b_sr, b_mv, b_mr;
  logic [31:0] b_md;  logic [15:0] b_drop;
  // c: N=2, 2-bit drop counter
  logic [7:0]  c_sd;  logic c_sv, c_ss, c_sr, c_mv, c_mr;
  logic [15:0] c_md;  logic [1:0]  c_drop;

  adc_path_pack #(.ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(2), .DROP_CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .s_data(a_sd), .s_valid(a_sv), .s_sync(a_ss), .s_ready(a_sr),
    .m_data(a_md), .m_valid(a_mv), .m_ready(a_mr), .drop_cnt(a_drop));
  adc_path_pack #(.ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(4), .DROP_CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst(rst), .s_data(b_sd), .s_valid(b_sv), .s_sync(b_ss), .s_ready(b_sr),
    .m_data(b_md), .m_valid(b_mv), .m_ready(b_mr), .drop_cnt(b_drop));
  adc_path_pack #(.ADC_DATA_WIDTH(8), .PARALLEL_PATH_NUM(2), .DROP_CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst(rst), .s_data(c_sd), .s_valid(c_sv), .s_sync(c_ss), .s_ready(c_sr),
    .m_data(c_md), .m_valid(c_mv), .m_ready(c_mr), .drop_cnt(c_drop));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One row = inputs held for one cycle, s_ready expected during that cycle,
  // registered outputs expected after the edge.
  typedef struct packed {
    logic        v, sy;
    logic [7:0]  d;
    logic        mr, er, emv;
    logic [15:0] emd;
    logic [15:0] edrop;
  } vec_t;
  vec_t vec[$];

  task automatic add(input logic v, input logic sy, input logic [7:0] d, input logic mr,
                     input logic er, input logic emv, input logic [15:0] emd,
                     input logic [15:0] edrop);
    vec_t t;
    t.v = v; t.sy = sy; t.d = d; t.mr = mr; t.er = er; t.emv = emv; t.emd = emd; t.edrop = edrop;
    vec.push_back(t);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs read 1 unit later.
  task automatic step_a(input logic v, input logic sy, input logic [7:0] d, input logic mr);
    a_sv = v; a_ss = sy; a_sd = d; a_mr = mr;
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  int lowcnt, words;

  initial begin
    rst = 1'b1;
    a_sv = 0; a_ss = 0; a_sd = 0; a_mr = 1;
    b_sv = 0; b_ss = 0; b_sd = 0; b_mr = 1;
    c_sv = 0; c_ss = 0; c_sd = 0; c_mr = 1;

    //   v  sy  d      mr  er emv md        drop
    add(1, 0, 8'h11, 1,  1, 0, 16'h0000, 0);   // basic pack
    add(1, 0, 8'h22, 1,  1, 1, 16'h2211, 0);
    add(0, 0, 8'h00, 1,  1, 0, 16'h2211, 0);
    add(1, 0, 8'hA1, 0,  1, 0, 16'h2211, 0);   // backpressure
    add(1, 0, 8'hA2, 0,  1, 1, 16'hA2A1, 0);
    add(1, 0, 8'hA3, 0,  1, 1, 16'hA2A1, 0);
    add(1, 0, 8'hA4, 0,  0, 1, 16'hA2A1, 0);
    add(1, 0, 8'hA4, 1,  1, 1, 16'hA4A3, 0);
    add(0, 0, 8'h00, 1,  1, 0, 16'hA4A3, 0);
    add(1, 0, 8'h11, 1,  1, 0, 16'hA4A3, 0);   // sync realign
    add(1, 1, 8'h33, 1,  1, 0, 16'hA4A3, 1);
    add(1, 0, 8'h44, 1,  1, 1, 16'h4433, 1);
    add(1, 1, 8'h55, 1,  1, 0, 16'h4433, 1);   // sync on lane 0: no drop
    add(1, 0, 8'h66, 1,  1, 1, 16'h6655, 1);
    add(0, 0, 8'h00, 1,  1, 0, 16'h6655, 1);
    add(1, 0, 8'h77, 0,  1, 0, 16'h6655, 1);
    add(1, 1, 8'h88, 0,  1, 0, 16'h6655, 2);   // sync on last lane, output empty
    add(1, 0, 8'h99, 1,  1, 1, 16'h9988, 2);
    add(0, 0, 8'h00, 1,  1, 0, 16'h9988, 2);
    add(1, 0, 8'h01, 1,  1, 0, 16'h9988, 2);
    add(0, 1, 8'hEE, 1,  1, 0, 16'h9988, 2);   // sync without valid ignored
    add(1, 0, 8'h02, 1,  1, 1, 16'h0201, 2);
    add(0, 0, 8'h00, 1,  1, 0, 16'h0201, 2);

    tick;
    chk("rst_sready", a_sr, 0);
    chk("rst_mvalid", a_mv, 0);
    chk("rst_mdata",  a_md, 0);
    chk("rst_drop",   a_drop, 0);
    tick;
    rst = 1'b0;

    foreach (vec[i]) begin
      step_a(vec[i].v, vec[i].sy, vec[i].d, vec[i].mr);
      chk($sformatf("v%0d_sready", i), a_sr, vec[i].er);
      @(posedge clk); #1;
      chk($sformatf("v%0d_mvalid", i), a_mv, vec[i].emv);
      chk($sformatf("v%0d_mdata", i),  a_md, vec[i].emd);
      chk($sformatf("v%0d_drop", i),   a_drop, vec[i].edrop);
    end

    // Streaming: 100 back-to-back samples, 50 words {2j+1, 2j}.
    lowcnt = 0; words = 0;
    for (int i = 0; i < 100; i++) begin
      step_a(1, 0, 8'(i), 1);
      if (!a_sr) lowcnt++;
      @(posedge clk); #1;
      if (a_mv) begin
        chk($sformatf("stream_w%0d", words), a_md, {8'(2*words+1), 8'(2*words)});
        words++;
      end
    end
    chk("stream_sready_low", lowcnt, 0);
    chk("stream_words", words, 50);
    step_a(0, 0, 0, 1);
    tick;

    // Reset with a stalled word and a partial word in flight.
    step_a(1, 0, 8'h10, 0); tick;
    step_a(1, 0, 8'h20, 0); tick;
    chk("rstmid_pending", a_mv, 1);
    step_a(1, 0, 8'h55, 0);
    chk("rstmid_lane0_ok", a_sr, 1);
    tick;
    rst = 1'b1;
    step_a(1, 0, 8'h99, 1);
    chk("rstmid_sready", a_sr, 0);
    tick;
    chk("rstmid_mvalid", a_mv, 0);
    chk("rstmid_mdata",  a_md, 0);
    chk("rstmid_drop",   a_drop, 0);
    rst = 1'b0;
    step_a(1, 0, 8'h66, 1); tick;
    chk("rstmid_partial_gone", a_mv, 0);
    step_a(1, 0, 8'h77, 1); tick;
    chk("rstmid_after_mv", a_mv, 1);
    chk("rstmid_after_md", a_md, 16'h7766);
    step_a(0, 0, 0, 1);

    // N=4 pack.
    for (int i = 1; i <= 4; i++) begin
      b_sv = 1; b_sd = 8'(i); #1;
      chk($sformatf("n4_sready%0d", i), b_sr, 1);
      tick;
      chk($sformatf("n4_mvalid%0d", i), b_mv, (i == 4) ? 1 : 0);
    end
    chk("n4_mdata", b_md, 32'h04030201);
    b_sv = 0; tick;
    chk("n4_clear", b_mv, 0);

    // Drop counter saturation with a 2-bit counter.
    c_sv = 1; c_ss = 0; c_sd = 8'h11; tick;
    for (int i = 1; i <= 5; i++) begin
      c_ss = 1; c_sd = 8'(8'h20 + i); tick;
      chk($sformatf("sat_drop%0d", i), c_drop, (i < 3) ? i : 3);
    end
    c_sv = 0; c_ss = 0; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
